// File: rtl/nn_pkg.sv
// Shared types and defaults for the network input stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nn_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    STREAM,
    WAIT
  } feeder_state_t;

  localparam int NUM_PIXELS = 784;
  localparam int PIX_WIDTH  = 8;
  localparam int FRAC_BITS  = 12;

  // States in which the upstream pixel port is open.
  function automatic logic accepts_pixels(feeder_state_t s);
    return (s == LOAD) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Single-port frame buffer, one pixel per word.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; a write and a read share the one address port.
module pixel_ram #(
  parameter int depth     = 784,
  parameter int width     = 8,
  parameter int addrWidth = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addrWidth-1:0] addr,
  input  logic [width-1:0]     wdata,
  output logic [width-1:0]     rdata
);

  logic [width-1:0] mem [depth];

  // Write on enable, always register the addressed word for reading.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pixel_feeder.sv
// Buffers one image from a byte stream, then replays it as fixed-point words to the network.
// Latency: first net_valid two cycles after the edge accepting the last pixel; burst is gap-free.
// Backpressure: pix_ready drops from image completion until net_done; the network side has none.
module pixel_feeder
  import nn_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int pixWidth  = PIX_WIDTH,
  parameter int numPixels = NUM_PIXELS,
  parameter int fracBits  = FRAC_BITS,
  parameter int addrWidth = $clog2(numPixels)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [pixWidth-1:0]  pix_data,
  input  logic                 pix_last,
  output logic                 net_valid,
  output logic [dataWidth-1:0] net_data,
  input  logic                 net_done,
  output logic                 busy,
  output logic                 frame_err
);

  localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(numPixels - 1);
  localparam logic [addrWidth-1:0] ONE       = addrWidth'(1);
  localparam int                   SHIFT     = fracBits - pixWidth;

  feeder_state_t        state;
  feeder_state_t        state_nxt;
  logic [addrWidth-1:0] wr_cnt;
  logic [addrWidth-1:0] wr_cnt_nxt;
  logic [addrWidth-1:0] rd_cnt;
  logic                 frame_err_nxt;
  logic                 pix_xfer;
  logic                 rd_vld;
  logic                 ram_we;
  logic [addrWidth-1:0] ram_addr;
  logic [pixWidth-1:0]  ram_rdata;
  logic [dataWidth-1:0] pix_ext;

  assign pix_xfer = pix_valid && pix_ready;
  // Only LOAD writes; DRAIN throws pixels away without touching the buffer.
  assign ram_we   = pix_xfer && (state == LOAD);
  assign ram_addr = (state == STREAM) ? rd_cnt : wr_cnt;
  assign pix_ext  = dataWidth'(ram_rdata);

  pixel_ram #(
    .depth    (numPixels),
    .width    (pixWidth),
    .addrWidth(addrWidth)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(pix_data),
    .rdata(ram_rdata)
  );

  // Next state, next write count and image-length error detection.
  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    frame_err_nxt = 1'b0;
    case (state)
      LOAD: begin
        if (pix_xfer) begin
          if (wr_cnt == LAST_ADDR) begin
            if (pix_last) begin
              state_nxt  = STREAM;
              wr_cnt_nxt = '0;
            end else begin
              // Image too long: flag once, then swallow pixels up to the next last.
              state_nxt     = DRAIN;
              frame_err_nxt = 1'b1;
            end
          end else if (pix_last) begin
            // Image too short: discard it and start over.
            wr_cnt_nxt    = '0;
            frame_err_nxt = 1'b1;
          end else begin
            wr_cnt_nxt = wr_cnt + ONE;
          end
        end
      end
      DRAIN: begin
        if (pix_xfer && pix_last) begin
          state_nxt  = LOAD;
          wr_cnt_nxt = '0;
        end
      end
      STREAM: begin
        if (rd_cnt == LAST_ADDR) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (net_done) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // State register, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      pix_ready <= 1'b1;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      frame_err <= frame_err_nxt;
      pix_ready <= accepts_pixels(state_nxt);
      busy      <= !((state_nxt == LOAD) && (wr_cnt_nxt == '0));
      // A read is issued on every STREAM cycle; its data lands one cycle later.
      rd_vld    <= (state == STREAM);
      if (state == STREAM) begin
        rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + ONE;
      end
    end
  end

  // Output stage: convert the RAM word to fixed point and present it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_valid <= 1'b0;
      net_data  <= '0;
    end else begin
      net_valid <= rd_vld;
      net_data  <= rd_vld ? (pix_ext << SHIFT) : '0;
    end
  end

endmodule
